// File: rtl/coord_mem_arbiter.sv
// coord_mem_arbiter
//
// Two-port arbiter and sequencer for the shared coordinate memory bus.
// Requester A (coordinate collector) and requester B (pathfinding engine)
// are serialised onto one registered master bus (mem_id/address/data/wren).
// That bus fans out to XMEM, YMEM and Node_ID_Mem. Read data from the
// selected memory is returned on a shared rdata bus, qualified per
// requester by a_rvalid / b_rvalid.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   a_* / b_*           : request, mem_id (0=X,1=Y,2=NID,3-7 illegal),
//                         addr, wdata, we (1=write)
//   a_gnt, b_gnt        : one-cycle grant pulse (ISSUE cycle)
//   a_rvalid, b_rvalid  : one-cycle read-data-valid pulse
//   rdata               : shared read data, holds until next capture
//   err                 : one-cycle pulse when an illegal mem_id is granted
//   busy                : state is not IDLE
//   *_master            : registered master bus to the memory decoder
//   xmem_q, ymem_q, nid_q : memory read outputs
//
// Configuration macro
//   COORD_ARB_FIXED_PRIO_EN : when defined, A always wins a tie (B can
//                             starve). Default is round-robin on a 'last'
//                             bit that resets to B.

module coord_mem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic [2:0]        a_mem_id,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_we,

    input  logic              b_req,
    input  logic [2:0]        b_mem_id,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              b_we,

    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,

    output logic [2:0]        mem_id_master,
    output logic [ADDR_W-1:0] address_master,
    output logic [DATA_W-1:0] data_master,
    output logic              wren_master,

    input  logic [7:0]        xmem_q,
    input  logic [7:0]        ymem_q,
    input  logic [3:0]        nid_q
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_READ
    } state_t;

    localparam logic [2:0] ID_XMEM = 3'd0;
    localparam logic [2:0] ID_YMEM = 3'd1;
    localparam logic [2:0] ID_NID  = 3'd2;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;      // 0 = A, 1 = B
    logic              we_q, we_d;
    logic [2:0]        mem_id_q, mem_id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wren_q, wren_d;
    logic              a_gnt_q, a_gnt_d;
    logic              b_gnt_q, b_gnt_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    // Arbitration result for the current IDLE cycle.
    logic              pick_b;
    logic              grant;

    // Winner's fields, muxed ahead of the bus registers.
    logic [2:0]        sel_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              sel_legal;

`ifdef COORD_ARB_FIXED_PRIO_EN
    // A takes every tie; no fairness state is kept.
    assign pick_b = b_req & ~a_req;
`else
    logic last_q, last_d;                     // 1 = B was granted last

    always_comb begin
        if (a_req && b_req) begin
            pick_b = ~last_q;
        end else begin
            pick_b = b_req;
        end
    end

    always_comb begin
        last_d = last_q;
        if (grant) begin
            last_d = pick_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        if (pick_b) begin
            sel_id    = b_mem_id;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
            sel_we    = b_we;
        end else begin
            sel_id    = a_mem_id;
            sel_addr  = a_addr;
            sel_wdata = a_wdata;
            sel_we    = a_we;
        end
        sel_legal = (sel_id <= ID_NID);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        mem_id_d   = mem_id_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rdata_d    = rdata_q;
        wren_d     = 1'b0;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        err_d      = 1'b0;
        grant      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (a_req || b_req) begin
                    grant    = 1'b1;
                    owner_d  = pick_b;
                    we_d     = sel_we;
                    mem_id_d = sel_id;
                    addr_d   = sel_addr;
                    data_d   = sel_wdata;
                    // An illegal target is still granted but never written.
                    wren_d   = sel_we & sel_legal;
                    err_d    = ~sel_legal;
                    a_gnt_d  = ~pick_b;
                    b_gnt_d  = pick_b;
                    state_d  = S_ISSUE;
                end
            end

            S_ISSUE: begin
                state_d = we_q ? S_IDLE : S_READ;
            end

            S_READ: begin
                case (mem_id_q)
                    ID_XMEM: rdata_d = DATA_W'(xmem_q);
                    ID_YMEM: rdata_d = DATA_W'(ymem_q);
                    ID_NID:  rdata_d = DATA_W'(nid_q);
                    default: rdata_d = '0;
                endcase
                a_rvalid_d = ~owner_q;
                b_rvalid_d = owner_q;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            mem_id_q   <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wren_q     <= 1'b0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            we_q       <= we_d;
            mem_id_q   <= mem_id_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wren_q     <= wren_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign a_gnt          = a_gnt_q;
    assign b_gnt          = b_gnt_q;
    assign a_rvalid       = a_rvalid_q;
    assign b_rvalid       = b_rvalid_q;
    assign rdata          = rdata_q;
    assign err            = err_q;
    assign busy           = (state_q != S_IDLE);
    assign mem_id_master  = mem_id_q;
    assign address_master = addr_q;
    assign data_master    = data_q;
    assign wren_master    = wren_q;

endmodule

// File: tb/tb_coord_mem_arbiter.sv
module tb_coord_mem_arbiter;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              a_req = 1'b0, b_req = 1'b0;
    logic [2:0]        a_mem_id = '0, b_mem_id = '0;
    logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
    logic [DATA_W-1:0] a_wdata = '0, b_wdata = '0;
    logic              a_we = 1'b0, b_we = 1'b0;
    logic              a_gnt, b_gnt, a_rvalid, b_rvalid, err, busy;
    logic [DATA_W-1:0] rdata;
    logic [2:0]        mem_id_master;
    logic [ADDR_W-1:0] address_master;
    logic [DATA_W-1:0] data_master;
    logic              wren_master;
    logic [7:0]        xmem_q = '0, ymem_q = '0;
    logic [3:0]        nid_q = '0;

    coord_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_mem_id(a_mem_id), .a_addr(a_addr), .a_wdata(a_wdata), .a_we(a_we),
        .b_req(b_req), .b_mem_id(b_mem_id), .b_addr(b_addr), .b_wdata(b_wdata), .b_we(b_we),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .rdata(rdata), .err(err), .busy(busy),
        .mem_id_master(mem_id_master), .address_master(address_master),
        .data_master(data_master), .wren_master(wren_master),
        .xmem_q(xmem_q), .ymem_q(ymem_q), .nid_q(nid_q)
    );

    always #5 clk = ~clk;

    // Memories behind the decoder: synchronous write, registered read.
    logic [7:0] xmem [256];
    logic [7:0] ymem [256];
    logic [3:0] nmem [32];

    always @(posedge clk) begin
        if (wren_master) begin
            case (mem_id_master)
                3'd0: xmem[address_master] <= data_master;
                3'd1: ymem[address_master] <= data_master;
                3'd2: nmem[address_master[4:0]] <= data_master[3:0];
                default: ;
            endcase
        end
        xmem_q <= xmem[address_master];
        ymem_q <= ymem[address_master];
        nid_q  <= nmem[address_master[4:0]];
    end

    // Reference model state.
    typedef struct {
        logic              who;     // 0 = A, 1 = B
        logic [2:0]        id;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
        logic [DATA_W-1:0] rd;
    } txn_t;

    typedef struct {
        logic              who;
        logic [DATA_W-1:0] rd;
        int                due;
    } rd_t;

    txn_t exp_q[$];
    rd_t  rd_q[$];
    logic [7:0] mx [256];
    logic [7:0] my [256];
    logic [3:0] mn [32];
    logic m_last = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level view: each access either updates the model memory
    // (legal write) or produces the value currently stored there.
    task automatic predict(input txn_t t_in);
        txn_t t;
        t = t_in;
        t.rd = '0;
        if (t.we) begin
            case (t.id)
                3'd0: mx[t.addr] = t.wdata;
                3'd1: my[t.addr] = t.wdata;
                3'd2: mn[t.addr[4:0]] = t.wdata[3:0];
                default: ;
            endcase
        end else begin
            case (t.id)
                3'd0: t.rd = mx[t.addr];
                3'd1: t.rd = my[t.addr];
                3'd2: t.rd = {4'h0, mn[t.addr[4:0]]};
                default: t.rd = '0;
            endcase
        end
        exp_q.push_back(t);
    endtask

    function automatic txn_t mk(input logic who, input logic [2:0] id, input logic [7:0] addr,
                                input logic [7:0] wdata, input logic we);
        txn_t t;
        t.who = who; t.id = id; t.addr = addr; t.wdata = wdata; t.we = we; t.rd = '0;
        return t;
    endfunction

    function automatic txn_t rand_txn(input logic who);
        logic [2:0] id;
        if ($urandom_range(0, 7) == 0) id = 3'($urandom_range(3, 7));
        else id = 3'($urandom_range(0, 2));
        return mk(who, id, 8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 1)));
    endfunction

    // Present one or two requests together, hold until granted.
    task automatic run_round(input logic ra, input logic rb, input txn_t ta, input txn_t tb);
        int n;
        if (ra && rb) begin
`ifdef COORD_ARB_FIXED_PRIO_EN
            predict(ta); predict(tb);
`else
            if (m_last) begin
                predict(ta); predict(tb); m_last = 1'b1;
            end else begin
                predict(tb); predict(ta); m_last = 1'b0;
            end
`endif
        end else if (ra) begin
            predict(ta); m_last = 1'b0;
        end else if (rb) begin
            predict(tb); m_last = 1'b1;
        end
        a_req = ra; a_mem_id = ta.id; a_addr = ta.addr; a_wdata = ta.wdata; a_we = ta.we;
        b_req = rb; b_mem_id = tb.id; b_addr = tb.addr; b_wdata = tb.wdata; b_we = tb.we;
        n = 0;
        while ((a_req || b_req) && n < 20) begin
            @(posedge clk); #1;
            if (a_gnt) a_req = 1'b0;
            if (b_gnt) b_req = 1'b0;
            n++;
        end
        if (a_req || b_req) begin
            chk("grant_timeout", {30'd0, a_req, b_req}, 32'd0);
            a_req = 1'b0; b_req = 1'b0;
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant or rvalid.
    int   cyc = 0;
    int   wr_idle_cyc = -1;
    txn_t mt;
    rd_t  mr;

    always @(negedge clk) begin
        if (!reset) begin
            cyc++;
            chk("gnt_onehot", {31'd0, a_gnt & b_gnt}, 32'd0);
            if (a_gnt || b_gnt) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
                end else begin
                    mt = exp_q.pop_front();
                    chk("gnt_owner", {30'd0, a_gnt, b_gnt}, mt.who ? 32'd1 : 32'd2);
                    chk("mem_id_master", 32'(mem_id_master), 32'(mt.id));
                    chk("address_master", 32'(address_master), 32'(mt.addr));
                    chk("data_master", 32'(data_master), 32'(mt.wdata));
                    chk("wren_master", 32'(wren_master), 32'(mt.we && mt.id <= 3'd2));
                    chk("err", 32'(err), 32'(mt.id > 3'd2));
                    chk("busy_issue", 32'(busy), 32'd1);
                    if (mt.we) wr_idle_cyc = cyc + 1;
                    else rd_q.push_back('{who: mt.who, rd: mt.rd, due: cyc + 2});
                end
            end else begin
                chk("wren_idle", 32'(wren_master), 32'd0);
                chk("err_idle", 32'(err), 32'd0);
            end
            if (a_rvalid || b_rvalid) begin
                if (rd_q.size() == 0 || rd_q[0].due != cyc) begin
                    chk("unexpected_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
                end else begin
                    mr = rd_q.pop_front();
                    chk("rvalid_owner", {30'd0, a_rvalid, b_rvalid}, mr.who ? 32'd1 : 32'd2);
                    chk("rdata", 32'(rdata), 32'(mr.rd));
                    chk("busy_rvalid", 32'(busy), 32'd0);
                end
            end else if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
                mr = rd_q.pop_front();
                chk("missing_rvalid", 32'd0, 32'd1);
            end
            if (cyc == wr_idle_cyc) chk("busy_after_write", 32'(busy), 32'd0);
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, {30'd0, a_gnt, b_gnt}, 32'd0);
        chk({tag, "_rvalid"}, {30'd0, a_rvalid, b_rvalid}, 32'd0);
        chk({tag, "_rdata"}, 32'(rdata), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_mem_id"}, 32'(mem_id_master), 32'd0);
        chk({tag, "_addr"}, 32'(address_master), 32'd0);
        chk({tag, "_data"}, 32'(data_master), 32'd0);
        chk({tag, "_wren"}, 32'(wren_master), 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rd_q.size() != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_exp", 32'(exp_q.size()), 32'd0);
        chk("drain_rd", 32'(rd_q.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            xmem[i] = '0; ymem[i] = '0; mx[i] = '0; my[i] = '0;
        end
        for (int i = 0; i < 32; i++) begin
            nmem[i] = '0; mn[i] = '0;
        end

        #1 reset = 1'b1;
        #2 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Directed accesses from the test plan.
        run_round(1, 0, mk(0, 3'd0, 8'h05, 8'h3C, 1), mk(1, 0, 0, 0, 0));
        run_round(1, 0, mk(0, 3'd1, 8'h10, 8'hA7, 1), mk(1, 0, 0, 0, 0));
        run_round(0, 1, mk(0, 0, 0, 0, 0), mk(1, 3'd1, 8'h10, 8'h00, 0));
        run_round(1, 1, mk(0, 3'd0, 8'h01, 8'h11, 1), mk(1, 3'd1, 8'h02, 8'h22, 1));
        run_round(1, 1, mk(0, 3'd0, 8'h03, 8'h33, 1), mk(1, 3'd1, 8'h04, 8'h44, 1));
        run_round(1, 0, mk(0, 3'd2, 8'h27, 8'hF9, 1), mk(1, 0, 0, 0, 0));
        run_round(0, 1, mk(0, 0, 0, 0, 0), mk(1, 3'd2, 8'h07, 8'h00, 0));
        run_round(1, 0, mk(0, 3'd5, 8'h06, 8'h55, 1), mk(1, 0, 0, 0, 0));
        run_round(1, 0, mk(0, 3'd5, 8'h06, 8'h00, 0), mk(1, 0, 0, 0, 0));

        // Randomised traffic.
        for (int r = 0; r < 200; r++) begin
            logic ra, rb;
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1'b1;
            run_round(ra, rb, rand_txn(1'b0), rand_txn(1'b1));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();

        // Reset during the READ cycle of a B read.
        run_round(0, 1, mk(0, 0, 0, 0, 0), mk(1, 3'd1, 8'h10, 8'h00, 0));
        @(posedge clk); #2;
        reset = 1'b1;
        #1 chk_all_zero("midreset");
        rd_q.delete();
        m_last = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_rvalid_after_reset", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        end
        @(posedge clk); #1;
        run_round(1, 0, mk(0, 3'd0, 8'h09, 8'h00, 0), mk(1, 0, 0, 0, 0));
        run_round(1, 1, rand_txn(1'b0), rand_txn(1'b1));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
